// File: rtl/systolic_pkg.sv
// Shared FSM encoding and default widths for the systolic matrix-multiply array.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 4;
  localparam int DEF_K_WIDTH    = 8;
  localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH + 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    OUTPUT,
    DONE
  } state_t;

endpackage

// File: rtl/sa_mac_pe.sv
// Output-stationary MAC cell: one accumulator plus A (rightward) / B (downward) forwarding registers.
// Accumulation wraps, or clamps when SYSTOLIC_SATURATE_EN is defined.
module sa_mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] a_fwd,
  output logic [DATA_WIDTH-1:0] b_fwd,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] addend;
  logic signed [ACC_WIDTH-1:0] acc_q;

  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] x,
    input logic signed [ACC_WIDTH-1:0] y
  );
`ifdef SYSTOLIC_SATURATE_EN
    logic signed [ACC_WIDTH:0] s;
    s = {x[ACC_WIDTH-1], x} + {y[ACC_WIDTH-1], y};
    // A disagreement between the two top bits means the true sum left the range.
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return s[ACC_WIDTH-1:0];
`else
    return x + y;
`endif
  endfunction

  assign prod   = PROD_W'($signed(a)) * PROD_W'($signed(b));
  assign addend = ACC_WIDTH'(prod);
  assign acc    = acc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_fwd <= '0;
      b_fwd <= '0;
      acc_q <= '0;
    end else begin
      a_fwd <= a;
      b_fwd <= b;
      if (clear) acc_q <= '0;
      else       acc_q <= acc_add(acc_q, addend);
    end
  end

endmodule

// File: rtl/systolic_matmul_array.sv
// ROWS x COLS output-stationary systolic matrix multiplier with skewed operand feed and row-serial readout.
// Optional build macro: SYSTOLIC_SATURATE_EN (saturating accumulation instead of wrap).
module systolic_matmul_array
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 8,
  parameter int K_WIDTH    = DEF_K_WIDTH,
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [K_WIDTH-1:0]               k_len,
  input  logic [ROWS-1:0]                  row_mask,
  input  logic [COLS-1:0]                  col_mask,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]  a_in,
  input  logic [COLS-1:0][DATA_WIDTH-1:0]  b_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ROW_W-1:0]                 out_row,
  output logic [COLS-1:0][ACC_WIDTH-1:0]   out_data,
  output logic                             busy,
  output logic                             done
);

  localparam int                  DRAIN_W    = $clog2(ROWS + COLS);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(ROWS + COLS - 2);
  localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [K_WIDTH-1:0]  K_ONE      = K_WIDTH'(1);

  state_t               state, state_nx;
  logic [K_WIDTH-1:0]   k_len_q, beat_cnt;
  logic [ROWS-1:0]      row_mask_q;
  logic [COLS-1:0]      col_mask_q;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [ROW_W-1:0]     next_row;
  logic                 xfer, clear, last_beat;

  logic [ROWS-1:0][COLS:0][DATA_WIDTH-1:0]     a_link;
  logic [ROWS:0][COLS-1:0][DATA_WIDTH-1:0]     b_link;
  logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0]    acc_all;
  logic [ROWS-1:0][DATA_WIDTH-1:0]             a_tail_unused;
  logic [COLS-1:0][DATA_WIDTH-1:0]             b_tail_unused;

  assign in_ready  = (state == LOAD);
  assign xfer      = in_ready && in_valid;
  assign clear     = (state == IDLE) && start;
  assign last_beat = xfer && (beat_cnt == k_len_q - K_ONE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign next_row  = out_row + ROW_W'(1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (k_len == '0) ? DRAIN : LOAD;
      LOAD:    if (last_beat) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nx = OUTPUT;
      OUTPUT:  if (out_valid && out_ready && out_row == LAST_ROW) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      k_len_q    <= '0;
      beat_cnt   <= '0;
      row_mask_q <= '0;
      col_mask_q <= '0;
      drain_cnt  <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_data   <= '0;
    end else begin
      state <= state_nx;
      if (clear) begin
        k_len_q    <= k_len;
        row_mask_q <= row_mask;
        col_mask_q <= col_mask;
        beat_cnt   <= '0;
        out_row    <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + K_ONE;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
      // Output stage is registered: the first OUTPUT cycle loads row 0, later rows load on handshake.
      if (state == OUTPUT) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= acc_all[out_row];
        end else if (out_ready) begin
          if (out_row == LAST_ROW) begin
            out_valid <= 1'b0;
          end else begin
            out_row  <= next_row;
            out_data <= acc_all[next_row];
          end
        end
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic [DATA_WIDTH-1:0] a_gate;
    assign a_gate = (xfer && row_mask_q[r]) ? a_in[r] : '0;
    if (r == 0) begin : g_direct
      assign a_link[r][0] = a_gate;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] dly [r];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < r; i++) dly[i] <= '0;
        end else begin
          dly[0] <= a_gate;
          for (int i = 1; i < r; i++) dly[i] <= dly[i-1];
        end
      end
      assign a_link[r][0] = dly[r-1];
    end
    assign a_tail_unused[r] = a_link[r][COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic [DATA_WIDTH-1:0] b_gate;
    assign b_gate = (xfer && col_mask_q[c]) ? b_in[c] : '0;
    if (c == 0) begin : g_direct
      assign b_link[0][c] = b_gate;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] dly [c];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < c; i++) dly[i] <= '0;
        end else begin
          dly[0] <= b_gate;
          for (int i = 1; i < c; i++) dly[i] <= dly[i-1];
        end
      end
      assign b_link[0][c] = dly[c-1];
    end
    assign b_tail_unused[c] = b_link[ROWS][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_mac_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .a       (a_link[r][c]),
        .b       (b_link[r][c]),
        .a_fwd   (a_link[r][c+1]),
        .b_fwd   (b_link[r+1][c]),
        .acc     (acc_all[r][c])
      );
    end
  end

endmodule

// File: tb/tb_systolic_matmul_array.sv
// Directed, table-driven bench for systolic_matmul_array (4x4, 16-bit operands, 32-bit accumulators).
module tb_systolic_matmul_array;

  localparam int DW = 16;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int AW = 32;
  localparam int KW = 8;
  localparam int NV = 5;
`ifdef SYSTOLIC_SATURATE_EN
  localparam int BIG_EXP = 2147483647;
`else
  localparam int BIG_EXP = -1073938429;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [KW-1:0] k_len = '0;
  logic [R-1:0]  row_mask = '0;
  logic [C-1:0]  col_mask = '0;
  logic [R-1:0][DW-1:0] a_in = '0;
  logic [C-1:0][DW-1:0] b_in = '0;
  logic in_ready, out_valid, busy, done;
  logic [1:0] out_row;
  logic [C-1:0][AW-1:0] out_data;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int                      k;
    logic [3:0]              rm;
    logic [3:0]              cm;
    bit                      toggle;
    logic [3:0][3:0][DW-1:0] a;
    logic [3:0][3:0][DW-1:0] b;
    logic [15:0][31:0]       exp;
  } vec_t;

  vec_t vecs[NV];

  systolic_matmul_array #(
    .DATA_WIDTH (DW),
    .ROWS       (R),
    .COLS       (C),
    .ACC_WIDTH  (AW),
    .K_WIDTH    (KW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .k_len     (k_len),
    .row_mask  (row_mask),
    .col_mask  (col_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " out_row"}, out_row, 0);
    check({tag, " out_data_zero"}, out_data == '0, 1);
  endtask

  task automatic run_job(input int vi, input int stall_row, input int stall_len);
    int beat, rows_got, lat, done_cnt, stall_cnt, tail;
    bit par;
    logic [C-1:0][AW-1:0] held_data;
    logic [1:0] held_row;
    beat = 0; rows_got = 0; lat = -1; done_cnt = 0; stall_cnt = 0; tail = -1; par = 1'b0;
    held_data = '0; held_row = '0;
    @(negedge clk);
    k_len = KW'(vecs[vi].k); row_mask = vecs[vi].rm; col_mask = vecs[vi].cm;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 200; n++) begin
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (tail < 0) tail = n;
      end
      if (out_valid && lat < 0) lat = n + 1;
      if (out_valid && int'(out_row) == stall_row && stall_cnt < stall_len) begin
        if (stall_cnt == 0) begin
          held_data = out_data; held_row = out_row;
        end else begin
          check($sformatf("v%0d stall out_row", vi), out_row, held_row);
          check($sformatf("v%0d stall out_data held", vi), out_data == held_data, 1);
        end
        stall_cnt++;
        out_ready = 1'b0;
        start = 1'b1;
      end else if (out_valid) begin
        out_ready = 1'b1;
        check($sformatf("v%0d row order", vi), out_row, rows_got);
        if (rows_got < R) begin
          for (int c = 0; c < C; c++)
            check($sformatf("v%0d C[%0d][%0d]", vi, rows_got, c), $signed(out_data[c]),
                  $signed(vecs[vi].exp[rows_got*C+c]));
        end
        rows_got++;
      end else begin
        out_ready = 1'b1;
      end
      if (in_ready && beat < vecs[vi].k) begin
        if (vecs[vi].toggle && par) begin
          in_valid = 1'b0; a_in = {R{16'h0007}}; b_in = {C{16'h0007}};
        end else begin
          in_valid = 1'b1; a_in = vecs[vi].a[beat]; b_in = vecs[vi].b[beat];
          beat++;
        end
        par = !par;
      end else begin
        in_valid = 1'b1; a_in = {R{16'h0005}}; b_in = {C{16'h0009}};
      end
      if (tail >= 0 && n >= tail + 3) break;
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    check($sformatf("v%0d rows delivered", vi), rows_got, R);
    check($sformatf("v%0d done pulses", vi), done_cnt, 1);
    if (!vecs[vi].toggle) check($sformatf("v%0d first out_valid cycle", vi), lat, vecs[vi].k + R + C + 1);
    check($sformatf("v%0d busy after done", vi), busy, 0);
    if (stall_len > 0) check($sformatf("v%0d stall cycles", vi), stall_cnt, stall_len);
  endtask

  initial begin
    int done_in_reset;
    // Vector 0: rank-1 outer product a={1,2,3,4}, b={5,6,7,8}
    vecs[0].k = 1; vecs[0].rm = 4'hF; vecs[0].cm = 4'hF; vecs[0].toggle = 1'b0;
    vecs[0].a = '0; vecs[0].b = '0;
    vecs[0].a[0] = {16'd4, 16'd3, 16'd2, 16'd1};
    vecs[0].b[0] = {16'd8, 16'd7, 16'd6, 16'd5};
    vecs[0].exp = {32'd32, 32'd28, 32'd24, 32'd20, 32'd24, 32'd21, 32'd18, 32'd15,
                   32'd16, 32'd14, 32'd12, 32'd10, 32'd8,  32'd7,  32'd6,  32'd5};
    // Vector 1: identity times B (1..16) with bubbles between beats
    vecs[1].k = 4; vecs[1].rm = 4'hF; vecs[1].cm = 4'hF; vecs[1].toggle = 1'b1;
    vecs[1].a[0] = {16'd0, 16'd0, 16'd0, 16'd1};
    vecs[1].a[1] = {16'd0, 16'd0, 16'd1, 16'd0};
    vecs[1].a[2] = {16'd0, 16'd1, 16'd0, 16'd0};
    vecs[1].a[3] = {16'd1, 16'd0, 16'd0, 16'd0};
    vecs[1].b[0] = {16'd4,  16'd3,  16'd2,  16'd1};
    vecs[1].b[1] = {16'd8,  16'd7,  16'd6,  16'd5};
    vecs[1].b[2] = {16'd12, 16'd11, 16'd10, 16'd9};
    vecs[1].b[3] = {16'd16, 16'd15, 16'd14, 16'd13};
    vecs[1].exp = {32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10, 32'd9,
                   32'd8,  32'd7,  32'd6,  32'd5,  32'd4,  32'd3,  32'd2,  32'd1};
    // Vector 2: masks 0101 / 1100, all operands 3, k=2
    vecs[2].k = 2; vecs[2].rm = 4'b0101; vecs[2].cm = 4'b1100; vecs[2].toggle = 1'b0;
    vecs[2].a = '0; vecs[2].b = '0;
    vecs[2].a[0] = {4{16'd3}}; vecs[2].a[1] = {4{16'd3}};
    vecs[2].b[0] = {4{16'd3}}; vecs[2].b[1] = {4{16'd3}};
    vecs[2].exp = '0;
    vecs[2].exp[2] = 32'd18; vecs[2].exp[3] = 32'd18;
    vecs[2].exp[10] = 32'd18; vecs[2].exp[11] = 32'd18;
    // Vector 3: 32767^2 summed three times overflows a 32-bit accumulator
    vecs[3].k = 3; vecs[3].rm = 4'hF; vecs[3].cm = 4'hF; vecs[3].toggle = 1'b0;
    vecs[3].a = '0; vecs[3].b = '0;
    for (int i = 0; i < 3; i++) begin
      vecs[3].a[i] = {4{16'd32767}};
      vecs[3].b[i] = {4{16'd32767}};
    end
    for (int i = 0; i < 16; i++) vecs[3].exp[i] = BIG_EXP;
    // Vector 4: k_len=0 returns zeros even with in_valid held high
    vecs[4].k = 0; vecs[4].rm = 4'hF; vecs[4].cm = 4'hF; vecs[4].toggle = 1'b0;
    vecs[4].a = '0; vecs[4].b = '0; vecs[4].exp = '0;

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_quiet("idle after reset");

    for (int v = 0; v < NV; v++) run_job(v, -1, 0);

    // Back-pressure on row 1, with start pulsed while busy
    run_job(0, 1, 5);

    // Abort during DRAIN, then rerun
    @(negedge clk);
    k_len = 8'd1; row_mask = 4'hF; col_mask = 4'hF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a_in = vecs[0].a[0]; b_in = vecs[0].b[0];
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("abort pre busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check_quiet("async abort");
    done_in_reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_in_reset++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_in_reset++;
    end
    check("no done after abort", done_in_reset, 0);
    check("idle after abort busy", busy, 0);
    run_job(0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_array.md
SYSTOLIC_MATMUL_ARRAY -- requirements
Module: systolic_matmul_array

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed operand width.
REQ-002 SHALL have parameter ROWS, default 4, PE rows (A channels).
REQ-003 SHALL have parameter COLS, default 4, PE columns (B channels).
REQ-004 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+8, signed accumulator width.
REQ-005 SHALL have parameter K_WIDTH, default 8, width of k_len.
REQ-006 SHALL have port clk, input, 1, the single clock; all state is rising-edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, begin a job when idle.
REQ-009 SHALL have port k_len, input, K_WIDTH, inner dimension, sampled on accepted start.
REQ-010 SHALL have ports row_mask and col_mask, input, ROWS and COLS, active-row and active-column enables, sampled on accepted start.
REQ-011 SHALL have ports in_valid (input, 1) and in_ready (output, 1), operand-beat handshake.
REQ-012 SHALL have ports a_in (input, ROWS x DATA_WIDTH) and b_in (input, COLS x DATA_WIDTH), one A column and one B row per beat.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_row (output, clog2(ROWS)), and out_data (output, COLS x ACC_WIDTH), result-row handshake.
REQ-014 SHALL have ports busy (output, 1) and done (output, 1), job status and one-cycle completion pulse.

Function
REQ-015 SHALL compute C[r][c] = sum over k of a_in[r]*b_in[c] over k_len accepted beats, output-stationary: one accumulator per PE.
REQ-016 SHALL skew inputs so row r sees A delayed r cycles and column c sees B delayed c cycles; A moves right and B moves down one PE per cycle.
REQ-017 SHALL implement FSM states IDLE, LOAD, DRAIN, OUTPUT, and DONE.
REQ-018 IDLE->LOAD on start; accumulators cleared in the same cycle; start outside IDLE SHALL be ignored.
REQ-019 LOAD: in_ready=1; a beat transfers on in_valid&&in_ready; in_valid low inserts zero bubbles that SHALL NOT accumulate; after the k_len-th transfer go to DRAIN.
REQ-020 k_len==0 SHALL go IDLE->DRAIN directly and return all-zero results.
REQ-021 DRAIN SHALL last exactly ROWS+COLS-1 cycles with in_ready=0, then go to OUTPUT.
REQ-022 OUTPUT SHALL present rows 0..ROWS-1 in order; out_data and out_row SHALL be held stable while out_valid&&!out_ready; the row advances on handshake.
REQ-023 After row ROWS-1 transfers, go to DONE; DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-024 Masked-off rows/columns SHALL feed zero operands, and their results SHALL read 0.
REQ-025 Products SHALL be full 2*DATA_WIDTH signed and sign-extended to ACC_WIDTH; the accumulation mode is per REQ-029/030.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Latency: with start accepted at cycle 0 and in_valid held high, first out_valid SHALL occur at cycle k_len+ROWS+COLS+1.

Reset
REQ-028 reset_n low SHALL asynchronously force IDLE and zero all accumulators and skew registers; in_ready, out_valid, busy, done, out_row, and out_data SHALL all be 0; assertion mid-job SHALL abort it with no done pulse.

Configuration
REQ-029 With SYSTOLIC_SATURATE_EN defined, accumulation SHALL clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and the accumulator SHALL remain at the clamp value when further addends push past it.
REQ-030 Without SYSTOLIC_SATURATE_EN, accumulation SHALL wrap modulo 2^ACC_WIDTH.

Structure
REQ-031 The FSM state enum and the default-width localparams SHALL reside in shared package systolic_pkg.
REQ-032 A sub-module sa_mac_pe SHALL hold one accumulator and the A/B forwarding registers, and SHALL be instantiated ROWS x COLS times via generate.

Verification
REQ-033 k_len=1, a_in={1,2,3,4}, b_in={5,6,7,8} -> C[r][c]=a[r]*b[c]; row 3 = {20,24,28,32}; first out_valid at cycle 10.
REQ-034 k_len=4, A=identity, B=rows {1..16} with in_valid toggling every cycle -> C equals B, and the bubbles do not change the result.
REQ-035 row_mask=4'b0101, col_mask=4'b1100, all operands 3, k_len=2 -> result is 18 where both masks are set, else 0.
REQ-036 out_ready held low 5 cycles on row 1 -> out_row and out_data stable; all 4 rows delivered once; done pulses exactly once.
REQ-037 ACC_WIDTH=32, k_len=3, all operands 32767 -> with SYSTOLIC_SATURATE_EN every C=2147483647; without it every C=-1073938429.
REQ-038 reset_n pulsed low during DRAIN -> all outputs 0 immediately; a new start then yields correct REQ-033 results.
